// File: rtl/l293d_pin_decoder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// l293d_pin_decoder : L293D pin read-back -> per-motor on/direction status
// Rev 1.0
// -----------------------------------------------------------------------------
module l293d_pin_decoder #(
  parameter int STABLE_CYCLES   = 4,
  parameter int DEADTIME_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_1,
  input  logic             input_1,
  input  logic             input_2,
  input  logic             enable_2,
  input  logic             input_3,
  input  logic             input_4,
  input  logic             fault_clr,
  output logic             motor_1_on,
  output logic             motor_1_dir,
  output logic             motor_2_on,
  output logic             motor_2_dir,
  output logic             change_1,
  output logic             change_2,
  output logic             fault_1,
  output logic             fault_2,
  output logic [CNT_W-1:0] rev_count_1,
  output logic [CNT_W-1:0] rev_count_2
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int DTW = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [SCW-1:0]   STABLE_MAX = SCW'(STABLE_CYCLES);
  localparam logic [DTW-1:0]   DEAD_MAX   = DTW'(DEADTIME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_FWD     = 2'd1,
    ST_REV     = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  logic [5:0]       pins_all;
  logic [1:0]       on_v;
  logic [1:0]       dir_v;
  logic [1:0]       chg_v;
  logic [1:0]       fault_v;
  logic [CNT_W-1:0] cnt_v [2];

  assign pins_all = {enable_2, input_3, input_4, enable_1, input_1, input_2};

  generate
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic [2:0]       sync1, sync2, last, filt;
      logic [SCW-1:0]   stable_cnt, stable_cnt_nx;
      state_t           state, state_nx;
      logic [DTW-1:0]   dead_timer, dead_timer_nx, dead_inc;
      logic             has_dir, has_dir_nx;
      logic             on_q, dir_q, chg_q, fault_q;
      logic             on_nx, dir_nx, fault_nx;
      logic [CNT_W-1:0] cnt_q, cnt_nx;
      logic             entry_drive, reversal, set_fault;

      // Synchroniser and stability filter on the whole {en,a,b} vector
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1      <= '0;
          sync2      <= '0;
          last       <= '0;
          stable_cnt <= '0;
          filt       <= '0;
        end else begin
          sync1      <= pins_all[ch*3 +: 3];
          sync2      <= sync1;
          last       <= sync2;
          stable_cnt <= stable_cnt_nx;
          if (stable_cnt_nx == STABLE_MAX) begin
            filt <= sync2;
          end
        end
      end

      always_comb begin
        stable_cnt_nx = stable_cnt;
        if (sync2 != last) begin
          stable_cnt_nx = SCW'(1);
        end else if (stable_cnt != STABLE_MAX) begin
          stable_cnt_nx = stable_cnt + SCW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state      <= ST_OFF;
          dead_timer <= DEAD_MAX;
          has_dir    <= 1'b0;
          on_q       <= 1'b0;
          dir_q      <= 1'b0;
          chg_q      <= 1'b0;
          fault_q    <= 1'b0;
          cnt_q      <= '0;
        end else begin
          state      <= state_nx;
          dead_timer <= dead_timer_nx;
          has_dir    <= has_dir_nx;
          on_q       <= on_nx;
          dir_q      <= dir_nx;
          chg_q      <= ({on_nx, dir_nx} != {on_q, dir_q});
          fault_q    <= fault_nx;
          cnt_q      <= cnt_nx;
        end
      end

      always_comb begin
        case (filt)
          3'b000:  state_nx = ST_OFF;
          3'b110:  state_nx = ST_FWD;
          3'b101:  state_nx = ST_REV;
          default: state_nx = ST_ILLEGAL;
        endcase

        // dead_inc is the OFF interval including the current cycle
        dead_inc      = (dead_timer == DEAD_MAX) ? dead_timer : dead_timer + DTW'(1);
        dead_timer_nx = dead_timer;
        if (state == ST_OFF) begin
          dead_timer_nx = dead_inc;
        end
        if ((state_nx == ST_OFF) && (state != ST_OFF)) begin
          dead_timer_nx = '0;
        end

        entry_drive = (state_nx != state) && ((state_nx == ST_FWD) || (state_nx == ST_REV));
        reversal    = entry_drive && has_dir && ((state_nx == ST_FWD) != dir_q);
        set_fault   = (state_nx == ST_ILLEGAL) ||
                      (reversal && ((state != ST_OFF) || (dead_inc < DEAD_MAX)));
        has_dir_nx  = has_dir | entry_drive;

        on_nx  = (state_nx == ST_FWD) || (state_nx == ST_REV);
        dir_nx = dir_q;
        if (state_nx == ST_FWD) begin
          dir_nx = 1'b1;
        end else if (state_nx == ST_REV) begin
          dir_nx = 1'b0;
        end

        cnt_nx = cnt_q;
        if (reversal && (cnt_q != CNT_MAX)) begin
          cnt_nx = cnt_q + CNT_W'(1);
        end

        // a set on the same edge as a clear wins
        fault_nx = set_fault | (fault_q & ~fault_clr);
      end

      assign on_v[ch]    = on_q;
      assign dir_v[ch]   = dir_q;
      assign chg_v[ch]   = chg_q;
      assign fault_v[ch] = fault_q;
      assign cnt_v[ch]   = cnt_q;
    end
  endgenerate

  assign motor_1_on  = on_v[0];
  assign motor_1_dir = dir_v[0];
  assign change_1    = chg_v[0];
  assign fault_1     = fault_v[0];
  assign rev_count_1 = cnt_v[0];
  assign motor_2_on  = on_v[1];
  assign motor_2_dir = dir_v[1];
  assign change_2    = chg_v[1];
  assign fault_2     = fault_v[1];
  assign rev_count_2 = cnt_v[1];

endmodule
`default_nettype wire

// File: tb/tb_l293d_pin_decoder.sv
`default_nettype none
// tb_l293d_pin_decoder : directed scenarios plus random pin stimulus, checked every
// cycle against a behavioural model of filtering, decoding, dead time and counters.
module tb_l293d_pin_decoder;

  localparam int S = 4;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable_1 = 1'b0, input_1 = 1'b0, input_2 = 1'b0;
  logic enable_2 = 1'b0, input_3 = 1'b0, input_4 = 1'b0;
  logic fault_clr = 1'b0;

  logic       a_on1, a_dir1, a_on2, a_dir2, a_chg1, a_chg2, a_flt1, a_flt2;
  logic [7:0] a_cnt1, a_cnt2;
  logic       b_on1, b_dir1, b_on2, b_dir2, b_chg1, b_chg2, b_flt1, b_flt2;
  logic [1:0] b_cnt1, b_cnt2;

  always #5 clk = ~clk;

  l293d_pin_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .enable_1(enable_1), .input_1(input_1), .input_2(input_2),
    .enable_2(enable_2), .input_3(input_3), .input_4(input_4),
    .fault_clr(fault_clr),
    .motor_1_on(a_on1), .motor_1_dir(a_dir1), .motor_2_on(a_on2), .motor_2_dir(a_dir2),
    .change_1(a_chg1), .change_2(a_chg2), .fault_1(a_flt1), .fault_2(a_flt2),
    .rev_count_1(a_cnt1), .rev_count_2(a_cnt2)
  );

  l293d_pin_decoder #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .enable_1(enable_1), .input_1(input_1), .input_2(input_2),
    .enable_2(enable_2), .input_3(input_3), .input_4(input_4),
    .fault_clr(fault_clr),
    .motor_1_on(b_on1), .motor_1_dir(b_dir1), .motor_2_on(b_on2), .motor_2_dir(b_dir2),
    .change_1(b_chg1), .change_2(b_chg2), .fault_1(b_flt1), .fault_2(b_flt2),
    .rev_count_1(b_cnt1), .rev_count_2(b_cnt2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int M_OFF = 0, M_FWD = 1, M_REV = 2, M_BAD = 3;
  int         m_mode[2];
  bit         m_on[2], m_dir[2], m_chg[2], m_fault[2], m_started[2];
  int         m_revs[2], m_off_len[2];
  logic [2:0] m_filt[2];
  logic [2:0] hist[2][S+2];

  function automatic int classify(input logic [2:0] v);
    if (v == 3'b000) return M_OFF;
    if (v == 3'b110) return M_FWD;
    if (v == 3'b101) return M_REV;
    return M_BAD;
  endfunction

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  function automatic logic [1:0] sat2(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = M_OFF; m_on[c] = 0; m_dir[c] = 0; m_chg[c] = 0; m_fault[c] = 0;
      m_started[c] = 0; m_revs[c] = 0; m_off_len[c] = D; m_filt[c] = 3'b000;
      for (int i = 0; i < S + 2; i++) hist[c][i] = 3'b000;
    end
  endtask

  task automatic model_tick();
    logic [2:0] now[2];
    now[0] = {enable_1, input_1, input_2};
    now[1] = {enable_2, input_3, input_4};
    for (int c = 0; c < 2; c++) begin
      int nxt;
      bit set, new_on, new_dir, agree;
      nxt = classify(m_filt[c]);
      set = (nxt == M_BAD);
      if (m_mode[c] == M_OFF) m_off_len[c]++;
      if (nxt != m_mode[c]) begin
        if (nxt == M_OFF) m_off_len[c] = 0;
        if (nxt == M_FWD || nxt == M_REV) begin
          if (m_started[c] && ((nxt == M_FWD) != m_dir[c])) begin
            m_revs[c]++;
            if (m_mode[c] != M_OFF || m_off_len[c] < D) set = 1;
          end
          m_started[c] = 1;
        end
      end
      new_on  = (nxt == M_FWD || nxt == M_REV);
      new_dir = (nxt == M_FWD) ? 1'b1 : (nxt == M_REV) ? 1'b0 : m_dir[c];
      m_chg[c]   = (new_on != m_on[c]) || (new_dir != m_dir[c]);
      m_on[c]    = new_on;
      m_dir[c]   = new_dir;
      m_fault[c] = set ? 1'b1 : (fault_clr ? 1'b0 : m_fault[c]);
      // synced view lags pins by two samples; accept once S samples agree
      for (int i = 0; i < S + 1; i++) hist[c][i] = hist[c][i+1];
      hist[c][S+1] = now[c];
      agree = 1;
      for (int i = 1; i < S; i++) if (hist[c][i] != hist[c][0]) agree = 0;
      if (agree) m_filt[c] = hist[c][0];
      m_mode[c] = nxt;
    end
  endtask

  task automatic compare_all();
    logic [31:0] obs, exp;
    obs = 32'({a_on1, a_dir1, a_chg1, a_flt1, a_cnt1});
    exp = 32'({m_on[0], m_dir[0], m_chg[0], m_fault[0], sat8(m_revs[0])});
    check("ch1", obs, exp);
    obs = 32'({a_on2, a_dir2, a_chg2, a_flt2, a_cnt2});
    exp = 32'({m_on[1], m_dir[1], m_chg[1], m_fault[1], sat8(m_revs[1])});
    check("ch2", obs, exp);
    obs = 32'({b_on1, b_dir1, b_chg1, b_flt1, b_cnt1, b_on2, b_dir2, b_chg2, b_flt2, b_cnt2});
    exp = 32'({m_on[0], m_dir[0], m_chg[0], m_fault[0], sat2(m_revs[0]),
               m_on[1], m_dir[1], m_chg[1], m_fault[1], sat2(m_revs[1])});
    check("w2", obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
    compare_all();
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic set1(input logic [2:0] v);
    {enable_1, input_1, input_2} = v;
  endtask

  task automatic set2(input logic [2:0] v);
    {enable_2, input_3, input_4} = v;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset", 32'({a_on1, a_dir1, a_on2, a_dir2, a_chg1, a_chg2, a_flt1, a_flt2,
                        a_cnt1, a_cnt2, b_on1, b_dir1, b_on2, b_dir2, b_chg1, b_chg2,
                        b_flt1, b_flt2, b_cnt1, b_cnt2}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] rand_vec();
    case ($urandom_range(0, 5))
      0, 1:    return 3'b000;
      2:       return 3'b110;
      3:       return 3'b101;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    bit seen;
    model_reset();
    #2;

    // 1: FWD held from reset appears at edge 7 with a single change pulse
    set1(3'b110); set2(3'b000);
    apply_reset();
    hold(6);
    check("t1_before", 32'(a_on1), 32'd0);
    tick();
    check("t1_fwd", 32'({a_on1, a_dir1, a_chg1, a_flt1, a_cnt1}), 32'({4'b1110, 8'd0}));
    tick();
    check("t1_pulse_end", 32'(a_chg1), 32'd0);

    // 2: short enable pulse is filtered out
    set2(3'b110);
    hold(3);
    set2(3'b000);
    seen = 0;
    repeat (12) begin
      tick();
      seen |= a_chg2 | a_on2 | a_flt2;
    end
    check("t2_glitch", 32'(seen), 32'd0);

    // 3: direct FWD -> REV
    set1(3'b101);
    hold(10);
    check("t3_direct", 32'({a_dir1, a_flt1, a_cnt1}), 32'({2'b01, 8'd1}));

    // 4: reversals with long and short OFF gaps
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("t4_clr", 32'(a_flt1), 32'd0);
    set1(3'b000); hold(20); set1(3'b110); hold(10);
    check("t4_long_fwd", 32'({a_flt1, a_cnt1}), 32'({1'b0, 8'd2}));
    set1(3'b000); hold(20); set1(3'b101); hold(10);
    check("t4_long_rev", 32'({a_flt1, a_cnt1}), 32'({1'b0, 8'd3}));
    set1(3'b000); hold(8); set1(3'b110); hold(10);
    check("t4_short", 32'({a_on1, a_dir1, a_flt1, a_cnt1}), 32'({3'b111, 8'd4}));

    // 5: illegal vectors, clear coinciding with illegal, clear while OFF
    set2(3'b111); hold(10);
    check("t5_illegal", 32'({a_on2, a_flt2}), 32'b01);
    set2(3'b010); hold(5);
    fault_clr = 1'b1; hold(3); fault_clr = 1'b0;
    check("t5_set_wins", 32'(a_flt2), 32'd1);
    set2(3'b000); hold(10);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("t5_clr_off", 32'(a_flt2), 32'd0);

    // 6: counter saturation on the narrow instance, then reset mid-FWD
    set1(3'b000); hold(20); set1(3'b101); hold(10);
    check("t6_sat_w2", 32'(b_cnt1), 32'd3);
    check("t6_cnt8", 32'(a_cnt1), 32'd5);
    set1(3'b000); hold(20); set1(3'b110); hold(10);
    check("t6_fwd", 32'({a_on1, b_on1}), 32'b11);
    apply_reset();
    hold(6);
    check("t6_reacq_wait", 32'(a_on1), 32'd0);
    tick();
    check("t6_reacq", 32'({a_on1, a_dir1}), 32'b11);

    // random phase
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      set1(rand_vec());
      set2(rand_vec());
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        fault_clr = ($urandom_range(0, 15) == 0);
        tick();
      end
      fault_clr = 1'b0;
      if ($urandom_range(0, 40) == 0) apply_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
